s2_arbiter: RTL and testbench
=============================

# s2_arbiter

Four-requester round-robin scheduler that shares the S2 mux-register between requesters 0..3. It grants one requester at a time and drives the S2 select inputs A1, B1, A0, B0 so that requester i's data (D00/D01/D10/D11 for i = 0/1/2/3) is captured. It also produces a valid/ID qualifier aligned with the S2 register output.

## Interface
- N, 5: data width of the companion S2 instance; not used internally, carried for integration checks.
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..15.
- CLK  input  1  clock, rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- req  input  4  request per requester; level, held until the requester is done.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- A1, B1, A0, B0  output  1 each  S2 select drive; A1 = owner[1], B1 = 0, A0 = B0 = owner[0].
- busy  output  1  high while in state BUSY.
- vld  output  1  S2 register output holds a granted requester's data.
- vid  output  2  index of the requester whose data is on the S2 output; valid when vld = 1.

## Operation
- Registered state: st (IDLE/BUSY), owner[1:0], ptr[1:0] (last granted), cnt[3:0], vld, vid.
- Reset values: st = IDLE, owner = 0, ptr = 3, cnt = 0, gnt = 0000, A1 = B1 = A0 = B0 = 0, busy = 0, vld = 0, vid = 0.
- Winner search: the first asserted req in the order ptr+1, ptr+2, ptr+3, ptr+4, modulo 4. The "others" search is the same order but excludes owner.
- IDLE:
  - If req = 0, stay.
  - Otherwise go to BUSY. Set owner = ptr = winner, gnt = onehot(winner), cnt = 1.
- BUSY, req[owner] = 0 (release):
  - If any other request is pending, hand over to the next winner in the same edge with cnt = 1.
  - Otherwise go to IDLE with gnt = 0. owner keeps its last value, so the select lines are unchanged.
- BUSY, req[owner] = 1, cnt < MAX_HOLD: keep the grant; cnt increments.
- BUSY, req[owner] = 1, cnt = MAX_HOLD:
  - If others are pending, rotate to the next winner with cnt = 1.
  - Otherwise keep the grant; cnt saturates at MAX_HOLD.
- Only one grant change per edge. gnt is always one-hot or zero.
- vld/vid pipeline: each edge sets vld <= busy and vid <= owner. This matches the one-cycle S2 register latency.

## Timing
- req rises before edge k from IDLE: gnt, busy and the select lines update after edge k.
- The S2 register captures the granted data at edge k+1. vld = 1 and vid = owner after edge k+1.
- Arbitration latency is one edge. Handover between requesters costs no idle cycle.
- Release: req[owner] falls before edge k. gnt changes after edge k; vld follows after edge k+1.
- Simultaneous requests are resolved by the round-robin order from ptr. After reset the order starts at requester 0.
- CLR mid-operation: all outputs return to their reset values immediately, asynchronously. The next arbitration starts from requester 0.
- A requester dropping and re-raising req in the same cycle it loses the grant waits its full round-robin turn.

## Configuration
- S2_ARB_URGENT_EN:
  - Defined: requester 0 is urgent. If req[0] = 1 and owner ≠ 0 in BUSY, the grant moves to requester 0 at the next edge regardless of cnt, with cnt = 1 and ptr = 0. From IDLE, requester 0 wins whenever req[0] = 1. While requester 0 holds the grant, the MAX_HOLD rotation rules apply normally.
  - Undefined: pure round-robin as above; requester 0 has no special treatment.

## Test plan
- Reset then single request: CLR pulse, req = 0100. Response: gnt = 0100, A1 = 1, A0 = B0 = 0 after the first edge; vld = 1, vid = 2 after the second edge. Deassert req: gnt = 0000, then vld = 0 one edge later.
- Simultaneous requests after reset: req = 1111 held. Grants go 0,1,2,3,0, each lasting exactly MAX_HOLD = 4 cycles, with no idle cycle between grants.
- Early release handover: requester 1 owns with cnt = 2, req = 1010 → 1000. gnt = 1000 next edge; vid = 3 one edge after that.
- Saturation: req = 0001 held 20 cycles. gnt stays 0001, cnt holds at 4, busy = 1 throughout.
- Async reset mid-grant: req = 0110, CLR asserted between edges while gnt = 0100. gnt = 0000, select lines = 0 and vld = 0 without waiting for an edge. After CLR falls, the first grant goes to requester 1.
- Urgent (S2_ARB_URGENT_EN defined): requester 3 owns with cnt = 1, req[0] rises. gnt = 0001 at the next edge. With the macro undefined, requester 3 keeps the grant until cnt = 4.

Source files
------------

// File: rtl/s2_arbiter.sv
// Four-requester round-robin scheduler driving the S2 mux-register selects, with a
// valid/ID qualifier aligned to the S2 output. Optional build macro: S2_ARB_URGENT_EN.
module s2_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       A1,
  output logic       B1,
  output logic       A0,
  output logic       B0,
  output logic       busy,
  output logic       vld,
  output logic [1:0] vid
);

  if (N < 1) begin : g_bad_n
    $error("s2_arbiter: N must be at least 1");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
    $error("s2_arbiter: MAX_HOLD must be in 1..15");
  end

  localparam logic [3:0] MAX_H = 4'(MAX_HOLD);

  typedef enum logic {ST_IDLE, ST_BUSY} st_t;

  // Handshake: req is a level held by requester i until done; gnt is its
  // registered acknowledgement. busy is the FSM state (1 = BUSY).
  st_t        r_st, w_st_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic       r_vld;
  logic [1:0] r_vid;

  logic [2:0] w_win;
  logic [2:0] w_oth;
  logic [1:0] w_idle_idx;
  logic       w_urgent;
  logic       w_take;
  logic [1:0] w_take_idx;

  // Returns {found, index} of the first set bit in order p+1, p+2, p+3, p+4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_win = rr_pick(req, r_ptr);
  assign w_oth = rr_pick(req & ~(4'b0001 << r_owner), r_ptr);

`ifdef S2_ARB_URGENT_EN
  assign w_idle_idx = req[0] ? 2'd0 : w_win[1:0];
  assign w_urgent   = (r_st == ST_BUSY) && req[0] && (r_owner != 2'd0);
`else
  assign w_idle_idx = w_win[1:0];
  assign w_urgent   = 1'b0;
`endif

  always_comb begin
    w_st_nxt    = r_st;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_take      = 1'b0;
    w_take_idx  = 2'd0;
    case (r_st)
      ST_IDLE: begin
        if (|req) begin
          w_take     = 1'b1;
          w_take_idx = w_idle_idx;
        end
      end
      ST_BUSY: begin
        if (w_urgent) begin
          w_take     = 1'b1;
          w_take_idx = 2'd0;
        end else if (!req[r_owner]) begin
          if (w_oth[2]) begin
            w_take     = 1'b1;
            w_take_idx = w_oth[1:0];
          end else begin
            // owner is kept so the select lines stay put while idle
            w_st_nxt  = ST_IDLE;
            w_gnt_nxt = 4'b0000;
            w_cnt_nxt = 4'd0;
          end
        end else if (r_cnt < MAX_H) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if (w_oth[2]) begin
          w_take     = 1'b1;
          w_take_idx = w_oth[1:0];
        end
      end
      default: begin
        w_st_nxt  = ST_IDLE;
        w_gnt_nxt = 4'b0000;
      end
    endcase
    if (w_take) begin
      w_st_nxt    = ST_BUSY;
      w_owner_nxt = w_take_idx;
      w_ptr_nxt   = w_take_idx;
      w_gnt_nxt   = 4'b0001 << w_take_idx;
      w_cnt_nxt   = 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_st    <= ST_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd3;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
      r_vld   <= 1'b0;
      r_vid   <= 2'd0;
    end else begin
      r_st    <= w_st_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      // one-cycle lag matches the S2 register capture latency
      r_vld   <= (r_st == ST_BUSY);
      r_vid   <= r_owner;
    end
  end

  assign gnt  = r_gnt;
  assign A1   = r_owner[1];
  assign B1   = 1'b0;
  assign A0   = r_owner[0];
  assign B0   = r_owner[0];
  assign busy = (r_st == ST_BUSY);
  assign vld  = r_vld;
  assign vid  = r_vid;

endmodule

// File: tb/tb_s2_arbiter.sv
// Directed scoreboard bench for s2_arbiter: expected {gnt, vld, vid} per cycle are
// queued as stimulus is planned, then popped and compared after each edge.
module tb_s2_arbiter;

  logic       CLK;
  logic       CLR;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       A1, B1, A0, B0;
  logic       busy;
  logic       vld;
  logic [1:0] vid;

  int n_checks;
  int n_errors;

  logic [6:0] exp_q[$];
  logic [3:0] req_q[$];

  s2_arbiter #(.N(5), .MAX_HOLD(4)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .req (req),
    .gnt (gnt),
    .A1  (A1),
    .B1  (B1),
    .A0  (A0),
    .B0  (B0),
    .busy(busy),
    .vld (vld),
    .vid (vid)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    req = 4'b0000;
    #2;
    CLR = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    req = 4'b0000;
    #3;
    n_checks++;
    if ({gnt, busy, vld, vid} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_outs got gnt=%b busy=%b vld=%b vid=%0d exp 0000 0 0 0", gnt, busy, vld, vid);
    end
    n_checks++;
    if ({A1, B1, A0, B0} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_sel got %b exp 0000", {A1, B1, A0, B0});
    end
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_single();
    pulse_clr();
    req = 4'b0100;
    tick();
    n_checks++;
    if ({gnt, busy} !== 5'b0100_1) begin
      n_errors++;
      $display("FAIL single_gnt got gnt=%b busy=%b exp 0100 1", gnt, busy);
    end
    n_checks++;
    if ({A1, B1, A0, B0} !== 4'b1000) begin
      n_errors++;
      $display("FAIL single_sel got %b exp 1000", {A1, B1, A0, B0});
    end
    tick();
    n_checks++;
    if ({vld, vid} !== 3'b1_10) begin
      n_errors++;
      $display("FAIL single_vld got vld=%b vid=%0d exp 1 2", vld, vid);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if ({gnt, busy, vld} !== 6'b0000_0_1) begin
      n_errors++;
      $display("FAIL single_release got gnt=%b busy=%b vld=%b exp 0000 0 1", gnt, busy, vld);
    end
    n_checks++;
    if ({A1, B1, A0, B0} !== 4'b1000) begin
      n_errors++;
      $display("FAIL single_idle_sel got %b exp 1000", {A1, B1, A0, B0});
    end
    tick();
    n_checks++;
    if (vld !== 1'b0) begin
      n_errors++;
      $display("FAIL single_vld_drop got %b exp 0", vld);
    end
  endtask

  // Drains req_q/exp_q: apply one req per cycle, compare {gnt,vld,vid} after the edge.
  task automatic run_queue(input string name);
    int cyc;
    logic [6:0] e;
    cyc = 0;
    while (exp_q.size() > 0) begin
      req = req_q.pop_front();
      tick();
      e = exp_q.pop_front();
      cyc++;
      n_checks++;
      if ({gnt, vld, vid} !== e) begin
        n_errors++;
        $display("FAIL %s cyc %0d got gnt=%b vld=%b vid=%0d exp gnt=%b vld=%b vid=%0d",
                 name, cyc, gnt, vld, vid, e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_round_robin();
    int own, prev;
    pulse_clr();
    for (int t = 1; t <= 20; t++) begin
      own  = ((t - 1) / 4) % 4;
      prev = (t >= 2) ? ((t - 2) / 4) % 4 : 0;
      req_q.push_back(4'b1111);
      exp_q.push_back({4'(4'b0001 << own), (t >= 2) ? 1'b1 : 1'b0, 2'(prev)});
    end
    run_queue("round_robin");
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    req_q.push_back(4'b0010); exp_q.push_back({4'b0010, 1'b0, 2'd0});
    req_q.push_back(4'b1010); exp_q.push_back({4'b0010, 1'b1, 2'd1});
    req_q.push_back(4'b1000); exp_q.push_back({4'b1000, 1'b1, 2'd1});
    req_q.push_back(4'b1000); exp_q.push_back({4'b1000, 1'b1, 2'd3});
    run_queue("early_release");
  endtask

  task automatic test_saturation();
    int bad;
    pulse_clr();
    req = 4'b0001;
    bad = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (gnt !== 4'b0001 || busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL saturation_hold got %0d bad cycles exp 0", bad);
    end
    req = 4'b0011;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL saturation_rotate got %b exp 0010", gnt);
    end
  endtask

  task automatic test_async_reset();
    pulse_clr();
    req = 4'b0110;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_errors++;
      $display("FAIL areset_pre got %b exp 0100", gnt);
    end
    #2;
    CLR = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, vld, A1, B1, A0, B0} !== 10'b0) begin
      n_errors++;
      $display("FAIL areset_clear got gnt=%b busy=%b vld=%b sel=%b exp all 0",
               gnt, busy, vld, {A1, B1, A0, B0});
    end
    #1;
    CLR = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL areset_restart got %b exp 0010", gnt);
    end
  endtask

  task automatic test_urgent();
    pulse_clr();
    req_q.push_back(4'b1000); exp_q.push_back({4'b1000, 1'b0, 2'd0});
`ifdef S2_ARB_URGENT_EN
    req_q.push_back(4'b1001); exp_q.push_back({4'b0001, 1'b1, 2'd3});
    req_q.push_back(4'b1001); exp_q.push_back({4'b0001, 1'b1, 2'd0});
`else
    req_q.push_back(4'b1001); exp_q.push_back({4'b1000, 1'b1, 2'd3});
    req_q.push_back(4'b1001); exp_q.push_back({4'b1000, 1'b1, 2'd3});
    req_q.push_back(4'b1001); exp_q.push_back({4'b1000, 1'b1, 2'd3});
    req_q.push_back(4'b1001); exp_q.push_back({4'b0001, 1'b1, 2'd3});
`endif
    run_queue("urgent");
  endtask

  task automatic test_random_single();
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      r = 2'($urandom_range(0, 3));
      pulse_clr();
      req = 4'b0001 << r;
      tick();
      tick();
      n_checks++;
      if ({gnt, vld, vid} !== {4'(4'b0001 << r), 1'b1, r}) begin
        n_errors++;
        $display("FAIL rand_single r=%0d got gnt=%b vld=%b vid=%0d", r, gnt, vld, vid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    CLR = 1'b1;
    req = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_urgent();
    test_random_single();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
